mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator-side load/store unit between the MIPS datapath and the word-organised data memory.
- Accepts one byte, halfword or word load/store request at a time from the pipeline.
- Drives the memory's address, write-data, MemWrite and MemRead signals from registers.
- Sub-word stores are done as read-modify-write. Returns sign- or zero-extended load data, or an error flag, through a one-cycle response pulse.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the attached data memory. Valid byte addresses are 0 to 4*MEM_WORDS-1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  pipeline presents a request
- req_ready  output  1  unit can accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  misaligned, out-of-range or illegal size; valid with resp_valid
- mem_addr  output  32  word-aligned byte address to memory (bits 1:0 = 0)
- mem_wdata  output  32  write data to memory
- mem_write  output  1  MemWrite to memory
- mem_read  output  1  MemRead to memory
- mem_rdata  input  32  ReadData from memory, combinational from mem_addr/mem_read

Behaviour:
- Reset (async, any state): state = IDLE. req_ready=1. resp_valid=0, resp_error=0, resp_rdata=0. mem_addr=0, mem_wdata=0, mem_write=0, mem_read=0. A request in flight is dropped and no response is issued.
- All memory-side and response outputs are registered. mem_write must be glitch-free.
- Memory write is level-sensitive, so mem_addr and mem_wdata are loaded on the same edge that raises mem_write and held until the edge that lowers it.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1. On req_valid at an edge, capture all request fields.
  - Error if size=11, or halfword with addr[0]=1, or word with addr[1:0]!=0, or addr >= 4*MEM_WORDS. An error goes to RESP with resp_error=1 and no memory access.
  - Otherwise: load -> READ; word store -> WRITE; byte/halfword store -> READ.
- READ: mem_read=1, mem_addr={addr[31:2],2'b00}. At the closing edge, capture mem_rdata. Load -> RESP; sub-word store -> WRITE.
- WRITE:
  - mem_write=1 for exactly one cycle.
  - Word store: mem_wdata = req_wdata.
  - Sub-word store: mem_wdata = captured word with only the target lane(s) replaced. Then -> RESP.
- RESP: resp_valid=1 for one cycle; then -> IDLE. req_ready=0 in every state except IDLE.
- Byte lanes are big-endian:
  - byte offset 0 = bits 31:24, 1 = 23:16, 2 = 15:8, 3 = 7:0.
  - halfword offset 0 = bits 31:16, offset 2 = bits 15:0.
- Loads: the selected lane is right-justified. Bits above it are filled with the lane MSB when req_signed=1, else zeros. req_signed is ignored for word loads and for stores.
- Latency, counted from the accepting edge to resp_valid high: load 2 cycles; word store 2; sub-word store 3; error 1.
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- req_valid in a non-IDLE state is ignored (req_ready=0). Back-to-back requests: next accept no earlier than the RESP->IDLE edge, so one IDLE cycle separates transactions.

Test Plan:
- Reset mid-transaction: assert reset during WRITE of a sub-word store -> mem_write drops to 0 immediately (async), no resp_valid; after release, IDLE with req_ready=1.
- Word store then load: store addr 0x10, data 0xDEADBEEF -> mem_write high 1 cycle with mem_addr=0x10. Load word 0x10 -> resp_rdata=0xDEADBEEF, 2 cycles after accept.
- Byte store RMW: memory[0x20]=0x11223344; store byte 0xAA at 0x22 -> memory becomes 0x1122AA44; mem_read precedes mem_write by exactly 1 cycle.
- Signed/unsigned loads from word 0x8000FF7F:
  - lb at offset 2 -> 0xFFFFFFFF; lbu at offset 3 -> 0x0000007F.
  - lh at offset 0 -> 0xFFFF8000; lhu at offset 0 -> 0x00008000.
- Errors, each giving resp_error=1, resp_rdata=0, 1-cycle latency, and mem_read/mem_write never asserted:
  - word load at 0x06
  - halfword store at 0x03
  - size=11
  - load at 4*MEM_WORDS
- Handshake: hold req_valid=1 continuously with two different requests -> second accepted only after the first resp_valid; no request is lost or duplicated.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-organised data memory.
// Big-endian lanes; sub-word stores use read-modify-write.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [31:0] ADDR_LIM = 32'(4 * MEM_WORDS);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q, mem_read_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        req_err;
    logic [4:0]  lane_sh;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic [31:0] load_ext;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (req_addr >= ADDR_LIM) req_err = 1'b1;
    end

    // Lane 0 sits in the most significant bits, so the shift is (3-offset)*8.
    always_comb begin
        lane_sh   = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        unique case (size_q)
            2'b00: begin
                lane_sh   = {~off_q, 3'b000};
                lane_mask = 32'h0000_00FF << lane_sh;
            end
            2'b01: begin
                lane_sh   = {~off_q[1], 4'b0000};
                lane_mask = 32'h0000_FFFF << lane_sh;
            end
            default: begin
                lane_sh   = 5'd0;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    always_comb begin
        merged = (mem_rdata & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
        byte_v = 8'(mem_rdata >> lane_sh);
        half_v = 16'(mem_rdata >> lane_sh);
        unique case (size_q)
            2'b00:   load_ext = {{24{signed_q & byte_v[7]}}, byte_v};
            2'b01:   load_ext = {{16{signed_q & half_v[15]}}, half_v};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_rdata_d = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    off_d    = req_addr[1:0];
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (req_write && req_size == 2'b10) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = READ;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    state_d     = WRITE;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_ext;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_write  = mem_write_q;
    assign mem_read   = mem_read_q;

endmodule
